// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states and
// the alignment/extent helpers used to reject illegal accesses.
package dmem_pkg;

    localparam int unsigned ADDRESS_WIDTH_DEF = 12;
    localparam int unsigned DATA_WIDTH_DEF    = 32;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Offset of the last byte touched, relative to the start address.
    function automatic logic [1:0] last_offset(input logic [1:0] size);
        case (size)
            SZ_WORD: return 2'd3;
            SZ_HALF: return 2'd1;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_WORD: return lo != 2'b00;
            SZ_HALF: return lo[0];
            SZ_BYTE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer moves only when a grant
// is actually issued.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    // Index of the port granted most recently; reset to 1 so port 0 wins first.
    logic r_last;

    always_comb begin
        o_gnt = '0;
        if (i_en) begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
                default: o_gnt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (|o_gnt) begin
            r_last <= o_gnt[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU (port 0) and loader/DMA (port 1) accesses onto a single
// data-memory port: grant, one RAM cycle, then a one-cycle done response.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  req_i,
    input  logic [1:0]                  we_i,
    input  logic [1:0][1:0]             size_i,
    input  logic [1:0][ADDRESS_WIDTH-1:0] addr_i,
    input  logic [1:0][DATA_WIDTH-1:0]  wdata_i,
    output logic [1:0]                  gnt_o,
    output logic [1:0]                  done_o,
    output logic                        err_o,
    output logic [DATA_WIDTH-1:0]       rdata_o,
    output logic                        ram_we_o,
    output logic [1:0]                  ram_type_o,
    output logic [ADDRESS_WIDTH-1:0]    ram_a_o,
    output logic [DATA_WIDTH-1:0]       ram_wd_o,
    input  logic [DATA_WIDTH-1:0]       ram_rd_i
);

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_owner;
    logic                     r_we;
    logic [1:0]               r_size;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_rdata;

    logic                     w_arb_en;
    logic [1:0]               w_gnt;
    logic                     w_sel;
    logic [ADDRESS_WIDTH:0]   w_end;
    logic                     w_err;

    // Arbiter is only enabled in IDLE and out of reset, so no grant can leak
    // while the latch is being cleared.
    assign w_arb_en = rst_n && (r_state == ST_IDLE);
    assign w_sel    = w_gnt[1];

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_arb_en),
        .i_req (req_i),
        .o_gnt (w_gnt)
    );

    // Carry out of the end-address sum means the access runs past the top.
    assign w_end = {1'b0, r_addr} + {{(ADDRESS_WIDTH-1){1'b0}}, last_offset(r_size)};
    assign w_err = (r_size == SZ_ILL) || misaligned(r_size, r_addr[1:0]) || w_end[ADDRESS_WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_size  <= SZ_WORD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && |w_gnt) begin
                r_owner <= w_sel;
                r_we    <= we_i[w_sel];
                r_size  <= size_i[w_sel];
                r_addr  <= addr_i[w_sel];
                r_wdata <= wdata_i[w_sel];
            end
            if (r_state == ST_ACCESS) begin
                r_rdata <= (!r_we && !w_err) ? ram_rd_i : '0;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        gnt_o      = '0;
        done_o     = '0;
        err_o      = 1'b0;
        rdata_o    = '0;
        ram_we_o   = 1'b0;
        ram_type_o = '0;
        ram_a_o    = '0;
        ram_wd_o   = '0;
        case (r_state)
            ST_IDLE: begin
                gnt_o = w_gnt;
                if (|w_gnt) w_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                ram_we_o   = r_we && !w_err;
                ram_type_o = r_size;
                ram_a_o    = r_addr;
                ram_wd_o   = r_wdata;
                w_next     = ST_RESP;
            end
            ST_RESP: begin
                done_o  = r_owner ? 2'b10 : 2'b01;
                err_o   = w_err;
                rdata_o = r_rdata;
                w_next  = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed accesses push expected
// responses; a negedge monitor pops and compares whenever done_o fires.
module tb_dmem_arbiter;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_i;
    logic [1:0]       we_i;
    logic [1:0][1:0]  size_i;
    logic [1:0][11:0] addr_i;
    logic [1:0][31:0] wdata_i;
    logic [1:0]       gnt_o;
    logic [1:0]       done_o;
    logic             err_o;
    logic [31:0]      rdata_o;
    logic             ram_we_o;
    logic [1:0]       ram_type_o;
    logic [11:0]      ram_a_o;
    logic [31:0]      ram_wd_o;
    logic [31:0]      ram_rd_i;

    typedef struct {
        int          port;
        logic        we;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   gcyc = -10;
    logic abort_mode = 1'b0;
    logic [7:0] mem [4096];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter #(.ADDRESS_WIDTH(12), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .we_i       (we_i),
        .size_i     (size_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .gnt_o      (gnt_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .rdata_o    (rdata_o),
        .ram_we_o   (ram_we_o),
        .ram_type_o (ram_type_o),
        .ram_a_o    (ram_a_o),
        .ram_wd_o   (ram_wd_o),
        .ram_rd_i   (ram_rd_i)
    );

    // Byte-addressed RAM with asynchronous, sign-extending read.
    logic [11:0] a0, a1, a2, a3;
    always_comb begin
        a0 = ram_a_o;
        a1 = a0 + 12'd1;
        a2 = a0 + 12'd2;
        a3 = a0 + 12'd3;
        case (ram_type_o)
            2'b00:   ram_rd_i = {mem[a3], mem[a2], mem[a1], mem[a0]};
            2'b01:   ram_rd_i = {{24{mem[a0][7]}}, mem[a0]};
            2'b10:   ram_rd_i = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
            default: ram_rd_i = '0;
        endcase
    end

    always @(posedge clk) begin
        if (ram_we_o) begin
            case (ram_type_o)
                2'b00: begin
                    mem[a0] <= ram_wd_o[7:0];
                    mem[a1] <= ram_wd_o[15:8];
                    mem[a2] <= ram_wd_o[23:16];
                    mem[a3] <= ram_wd_o[31:24];
                end
                2'b01: mem[a0] <= ram_wd_o[7:0];
                2'b10: begin
                    mem[a0] <= ram_wd_o[7:0];
                    mem[a1] <= ram_wd_o[15:8];
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: grant order, RAM write cycle, done latency and response data.
    initial begin
        exp_t x;
        logic exp_we;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (gnt_o != 2'b00) begin
                    if (!abort_mode) begin
                        if (q.size() == 0) chk("gnt_unexpected", 32'(gnt_o), 32'd0);
                        else               chk("gnt_port", 32'(gnt_o), 32'(1 << q[0].port));
                    end
                    gcyc = cyc;
                end
                if (!abort_mode) begin
                    exp_we = (q.size() > 0 && cyc == gcyc + 1) ? q[0].we : 1'b0;
                    chk("ram_we", 32'(ram_we_o), 32'(exp_we));
                end
                if (done_o != 2'b00) begin
                    if (q.size() == 0) begin
                        chk("done_unexpected", 32'(done_o), 32'd0);
                    end else begin
                        x = q.pop_front();
                        chk("done_port", 32'(done_o), 32'(1 << x.port));
                        chk("err", 32'(err_o), 32'(x.err));
                        chk("rdata", rdata_o, x.rd);
                        chk("latency", 32'(cyc - gcyc), 32'd2);
                    end
                end else begin
                    chk("idle_err", 32'(err_o), 32'd0);
                    chk("idle_rdata", rdata_o, 32'd0);
                end
            end
        end
    end

    task automatic setp(input int p, input logic we, input logic [1:0] sz, input logic [11:0] a,
                        input logic [31:0] wd, input logic e, input logic [31:0] rd);
        exp_t x;
        we_i[p]    = we;
        size_i[p]  = sz;
        addr_i[p]  = a;
        wdata_i[p] = wd;
        x.port = p;
        x.we   = we & ~e;
        x.err  = e;
        x.rd   = rd;
        q.push_back(x);
    endtask

    // Raise requests, drop each one the cycle after its grant, then drain.
    task automatic go(input logic [1:0] mask);
        logic [1:0] pend;
        logic [1:0] g;
        int waited;
        pend   = mask;
        waited = 0;
        req_i  = mask;
        while (pend != 2'b00 && waited < 20) begin
            @(negedge clk);
            g = gnt_o;
            @(posedge clk);
            #1;
            pend  = pend & ~g;
            req_i = req_i & ~g;
            waited++;
        end
        req_i = '0;
        if (pend != 2'b00) begin
            chk("grant_timeout", 32'(pend), 32'd0);
        end else begin
            chk("grant_wait", 32'(waited), (mask == 2'b11) ? 32'd4 : 32'd1);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        rst_n   = 1'b0;
        req_i   = '0;
        we_i    = '0;
        size_i  = '0;
        addr_i  = '0;
        wdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_ram_we", 32'(ram_we_o), 32'd0);
        chk("rst_ram_a", 32'(ram_a_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Both ports after reset: port 0 first, then port 1.
        setp(0, 1'b1, 2'b00, 12'h100, 32'hDEADBEEF, 1'b0, 32'h0);
        setp(1, 1'b0, 2'b00, 12'h100, 32'h0, 1'b0, 32'hDEADBEEF);
        go(2'b11);
        setp(0, 1'b0, 2'b00, 12'h100, 32'h0, 1'b0, 32'hDEADBEEF);
        setp(1, 1'b1, 2'b01, 12'h101, 32'h00000080, 1'b0, 32'h0);
        go(2'b11);
        // Byte 0x80 sign-extended.
        setp(0, 1'b0, 2'b01, 12'h101, 32'h0, 1'b0, 32'hFFFFFF80);
        go(2'b01);
        // Port 0 granted last, so port 1 now goes first.
        setp(1, 1'b0, 2'b10, 12'h102, 32'h0, 1'b0, 32'hFFFFDEAD);
        setp(0, 1'b0, 2'b00, 12'h100, 32'h0, 1'b0, 32'hDEAD80EF);
        go(2'b11);
        // Illegal size and misaligned word store.
        setp(1, 1'b1, 2'b11, 12'h000, 32'h11111111, 1'b1, 32'h0);
        setp(0, 1'b1, 2'b00, 12'h102, 32'h22222222, 1'b1, 32'h0);
        go(2'b11);
        // Halfword at the top byte is rejected.
        setp(0, 1'b0, 2'b10, 12'hFFF, 32'h0, 1'b1, 32'h0);
        go(2'b01);
        // Highest legal word.
        setp(1, 1'b1, 2'b00, 12'hFFC, 32'h12345678, 1'b0, 32'h0);
        setp(0, 1'b0, 2'b00, 12'hFFC, 32'h0, 1'b0, 32'h12345678);
        go(2'b11);

        // Reset during ACCESS of a store.
        abort_mode = 1'b1;
        we_i[0] = 1'b1; size_i[0] = 2'b00; addr_i[0] = 12'h200; wdata_i[0] = 32'hCAFEF00D;
        req_i = 2'b01;
        @(negedge clk);
        chk("abort_gnt", 32'(gnt_o), 32'd1);
        @(posedge clk);
        #1;
        req_i = '0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_done", 32'(done_o), 32'd0);
        chk("abort_ram_we", 32'(ram_we_o), 32'd0);
        @(posedge clk);
        #1;
        abort_mode = 1'b0;

        // Pointer back to port 0, FSM idle.
        setp(0, 1'b0, 2'b00, 12'h100, 32'h0, 1'b0, 32'hDEAD80EF);
        setp(1, 1'b0, 2'b01, 12'h103, 32'h0, 1'b0, 32'hFFFFFFDE);
        go(2'b11);
        setp(0, 1'b1, 2'b00, 12'h100, 32'hDEADBEEF, 1'b0, 32'h0);
        go(2'b01);
        setp(0, 1'b0, 2'b00, 12'h100, 32'h0, 1'b0, 32'hDEADBEEF);
        go(2'b01);

        repeat (2) @(posedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 12, data-memory byte-address width (0x000-0xFFF).
REQ-002 Parameter DATA_WIDTH, default 32, word width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_i[p], p=0 (CPU load/store), p=1 (loader/DMA)  input  1 each  access request, held until gnt_o[p].
REQ-006 we_i[p]  input  1 each  1 = store, 0 = load.
REQ-007 size_i[p]  input  2 each  00 word, 01 byte, 10 halfword, 11 illegal.
REQ-008 addr_i[p]  input  ADDRESS_WIDTH each  byte address.
REQ-009 wdata_i[p]  input  DATA_WIDTH each  store data, LS-aligned.
REQ-010 gnt_o[p]  output  1 each  one-cycle pulse: request accepted and latched.
REQ-011 done_o[p]  output  1 each  one-cycle pulse: access complete (loads and stores).
REQ-012 err_o  output  1  qualifies done_o: access rejected, RAM untouched.
REQ-013 rdata_o  output  DATA_WIDTH  load result, valid while any done_o is high.
REQ-014 ram_we_o  output  1  RAM write enable.
REQ-015 ram_type_o  output  2  RAM dataType (00 word, 01 byte, 10 halfword).
REQ-016 ram_a_o  output  ADDRESS_WIDTH  RAM address.
REQ-017 ram_wd_o  output  DATA_WIDTH  RAM write data.
REQ-018 ram_rd_i  input  DATA_WIDTH  RAM asynchronous read data (sign-extended by RAM).

Function
REQ-019 FSM states: IDLE, ACCESS, RESP; transitions IDLE->ACCESS on grant, ACCESS->RESP always, RESP->IDLE always.
REQ-020 IDLE: if any req_i high, grant exactly one port, pulse its gnt_o, latch we/size/addr/wdata and owner.
REQ-021 Arbitration: round-robin; with both requesting, grant the port not granted last; a single requester wins immediately.
REQ-022 ACCESS: drive ram_a_o/ram_type_o/ram_wd_o from latched values; ram_we_o = latched we AND NOT error, for this cycle only.
REQ-023 ACCESS load: register ram_rd_i into rdata_o at end of cycle.
REQ-024 RESP: pulse done_o[owner] for one cycle; rdata_o holds captured value (zero for stores or errors).
REQ-025 Latency: gnt_o in cycle N, RAM access in N+1, done_o in N+2; a new grant is possible no earlier than N+3.
REQ-026 Error: size 11, word with addr[1:0]!=0, halfword with addr[0]!=0, or last accessed byte > 0xFFF; err_o=1 with done_o, no RAM write, rdata_o=0.
REQ-027 Outside ACCESS, ram_we_o=0 and ram_a_o/ram_type_o/ram_wd_o=0.
REQ-028 err_o, rdata_o and done_o are 0 outside RESP.
REQ-029 req_i changes after gnt_o do not affect the in-flight access.
REQ-030 At most one gnt_o and one done_o high in any cycle.

Reset
REQ-031 rst_n=0 at posedge: state IDLE, round-robin pointer favours port 0, all outputs 0, latched request cleared.
REQ-032 Reset mid-ACCESS or mid-RESP aborts: no done_o, no ram_we_o in the following cycle.

Structure
REQ-033 Package dmem_pkg holds size encodings (SZ_WORD, SZ_BYTE, SZ_HALF), FSM state enum and ADDRESS_WIDTH default.
REQ-034 Sub-module rr_arb2 (2-way round-robin, update-on-grant) is instantiated once; the rest is flat.

Verification
REQ-035 Port 0 store word 0xDEADBEEF @0x100, then load word @0x100 -> gnt N, ram_we_o at N+1, done N+2; load returns 0xDEADBEEF.
REQ-036 Both ports request in the same cycle after reset -> port 0 granted first, port 1 granted at the next IDLE; repeat -> alternation.
REQ-037 Byte load @0x101 where RAM holds 0x80 -> rdata_o=0xFFFFFF80, err_o=0.
REQ-038 Word store @0x102 and size 11 @0x000 -> done_o with err_o=1, ram_we_o never asserted, rdata_o=0.
REQ-039 Word load @0xFFC accepted; halfword @0xFFF rejected with err_o=1.
REQ-040 rst_n low during ACCESS of a store -> no done_o, ram_we_o=0 the following cycle, FSM back in IDLE.
